// File: rtl/uart_alu_pkg.sv
// Shared types and constants for the UART-driven ALU engine:
// operation codes, frame states, frame header and flag bit positions.
package uart_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_SAR = 3'd7
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_OPC  = 3'd1,
        ST_OPA  = 3'd2,
        ST_OPB  = 3'd3,
        ST_EXEC = 3'd4
    } frame_state_e;

    localparam logic [7:0] HEADER_BYTE = 8'hA5;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

endpackage

// File: rtl/uart_alu_engine_pwm.sv
// Free-running PWM generator. The duty shadow register only reloads when the
// counter wraps, so every period is complete and the output never glitches.
module pwm_gen #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] duty_in,
    output logic                pwm_out
);

    logic [PWM_BITS-1:0] cnt;
    logic [PWM_BITS-1:0] duty;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            duty    <= '0;
            pwm_out <= 1'b0;
        end else begin
            cnt     <= cnt + 1'b1;
            if (cnt == '1) begin
                duty <= duty_in;
            end
            pwm_out <= (cnt < duty);
        end
    end

endmodule

// File: rtl/uart_alu_engine.sv
// Byte-stream command engine: parses A5/opcode/A/B frames from the UART
// receiver, executes them on a registered ALU and drives a PWM from the result.
module uart_alu_engine
    import uart_alu_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int PWM_BITS       = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             done,
    output logic             busy,
    output logic             err_timeout,
    output logic             pwm_out
);

    localparam int NB  = WIDTH / 8;
    localparam int SHW = $clog2(WIDTH);
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] S_IDLE = ST_IDLE;
    localparam logic [2:0] S_OPC  = ST_OPC;
    localparam logic [2:0] S_OPA  = ST_OPA;
    localparam logic [2:0] S_OPB  = ST_OPB;
    localparam logic [2:0] S_EXEC = ST_EXEC;

    logic [2:0]       state;
    alu_op_e          op_q;
    logic             chain_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       byte_cnt;
    logic [TW-1:0]    tmo_cnt;

    logic [WIDTH-1:0] op_a;
    logic [SHW-1:0]   sh;
    logic [WIDTH:0]   ext;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic [3:0]       alu_flags;
    logic             last_byte;

    // Chain mode reuses the current result; it cannot change mid-frame.
    assign op_a      = chain_q ? result : a_q;
    assign sh        = b_q[SHW-1:0];
    assign last_byte = (byte_cnt == 3'(NB - 1));

    always_comb begin
        ext     = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_q)
            OP_ADD: begin
                ext     = {1'b0, op_a} + {1'b0, b_q};
                alu_res = ext[WIDTH-1:0];
                alu_c   = ext[WIDTH];
                alu_v   = (op_a[WIDTH-1] == b_q[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_SUB: begin
                ext     = {1'b0, op_a} - {1'b0, b_q};
                alu_res = ext[WIDTH-1:0];
                alu_c   = ext[WIDTH];
                alu_v   = (op_a[WIDTH-1] != b_q[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_AND: alu_res = op_a & b_q;
            OP_OR:  alu_res = op_a | b_q;
            OP_XOR: alu_res = op_a ^ b_q;
            // Shifts carry one guard bit so the last bit shifted out lands in ext.
            OP_SHL: begin
                ext     = {1'b0, op_a} << sh;
                alu_res = ext[WIDTH-1:0];
                alu_c   = ext[WIDTH];
            end
            OP_SHR: begin
                ext     = {op_a, 1'b0} >> sh;
                alu_res = ext[WIDTH:1];
                alu_c   = ext[0];
            end
            OP_SAR: begin
                ext     = $signed({op_a, 1'b0}) >>> sh;
                alu_res = ext[WIDTH:1];
                alu_c   = ext[0];
            end
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        alu_flags         = '0;
        alu_flags[FLAG_Z] = (alu_res == '0);
        alu_flags[FLAG_N] = alu_res[WIDTH-1];
        alu_flags[FLAG_C] = alu_c;
        alu_flags[FLAG_V] = alu_v;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            op_q        <= OP_ADD;
            chain_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            byte_cnt    <= '0;
            tmo_cnt     <= '0;
            result      <= '0;
            flags       <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            done        <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    tmo_cnt <= '0;
                    if (rx_valid && rx_data == HEADER_BYTE) begin
                        state <= S_OPC;
                        busy  <= 1'b1;
                    end
                end
                S_OPC, S_OPA, S_OPB: begin
                    // An arriving byte beats a timeout expiring in the same cycle.
                    if (rx_valid) begin
                        tmo_cnt <= '0;
                        if (state == S_OPC) begin
                            op_q     <= alu_op_e'(rx_data[2:0]);
                            chain_q  <= rx_data[3];
                            a_q      <= '0;
                            b_q      <= '0;
                            byte_cnt <= '0;
                            state    <= rx_data[3] ? S_OPB : S_OPA;
                        end else if (state == S_OPA) begin
                            a_q <= (a_q << 8) | WIDTH'(rx_data);
                            if (last_byte) begin
                                byte_cnt <= '0;
                                state    <= S_OPB;
                            end else begin
                                byte_cnt <= byte_cnt + 3'd1;
                            end
                        end else begin
                            b_q <= (b_q << 8) | WIDTH'(rx_data);
                            if (last_byte) begin
                                byte_cnt <= '0;
                                state    <= S_EXEC;
                            end else begin
                                byte_cnt <= byte_cnt + 3'd1;
                            end
                        end
                    end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        tmo_cnt     <= '0;
                        state       <= S_IDLE;
                        busy        <= 1'b0;
                        err_timeout <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_EXEC: begin
                    result <= alu_res;
                    flags  <= alu_flags;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    pwm_gen #(
        .PWM_BITS(PWM_BITS)
    ) u_pwm (
        .clk     (clk),
        .rst     (rst),
        .duty_in (result[WIDTH-1 -: PWM_BITS]),
        .pwm_out (pwm_out)
    );

endmodule

// File: tb/tb_uart_alu_engine.sv
// Bench for uart_alu_engine: an 8-bit instance driven from a vector table and
// corner-case sequences, plus a 16-bit instance for multi-byte operands.
module tb_uart_alu_engine;

    localparam int TO = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data16 = 8'h00;
    logic        rx_valid16 = 1'b0;

    logic [7:0]  result;
    logic [3:0]  flags;
    logic        done, busy, err_timeout, pwm_out;
    logic [15:0] result16;
    logic [3:0]  flags16;
    logic        done16, busy16, err16, pwm16;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    logic [11:0] exp_q[$];
    logic [19:0] exp16_q[$];

    typedef struct {
        logic [7:0] opc;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [3:0] flg;
    } vec_t;

    vec_t vecs[15];

    uart_alu_engine #(.WIDTH(8), .PWM_BITS(8), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .result(result), .flags(flags), .done(done), .busy(busy),
        .err_timeout(err_timeout), .pwm_out(pwm_out)
    );

    uart_alu_engine #(.WIDTH(16), .PWM_BITS(8), .TIMEOUT_CYCLES(TO)) dut16 (
        .clk(clk), .rst(rst), .rx_data(rx_data16), .rx_valid(rx_valid16),
        .result(result16), .flags(flags16), .done(done16), .busy(busy16),
        .err_timeout(err16), .pwm_out(pwm16)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Scoreboards: pop one expected {flags,result} per done pulse.
    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done8 unexpected: result %0h flags %0h with no pending frame", result, flags);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                check("result8", 32'(result), 32'(e[7:0]));
                check("flags8", 32'(flags), 32'(e[11:8]));
            end
        end
        if (!rst && err_timeout) err_cnt++;
    end

    always @(negedge clk) begin
        if (!rst && done16) begin
            if (exp16_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done16 unexpected: result %0h flags %0h with no pending frame", result16, flags16);
            end else begin
                logic [19:0] e;
                e = exp16_q.pop_front();
                check("result16", 32'(result16), 32'(e[15:0]));
                check("flags16", 32'(flags16), 32'(e[19:16]));
            end
        end
    end

    task automatic send_byte(input bit w16, input logic [7:0] b);
        if (w16) begin
            rx_data16  = b;
            rx_valid16 = 1'b1;
        end else begin
            rx_data  = b;
            rx_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        rx_valid   = 1'b0;
        rx_valid16 = 1'b0;
    endtask

    task automatic send_frame(input bit w16, input logic [7:0] opc, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] exp_res, input logic [3:0] exp_flg);
        int nb;
        nb = w16 ? 2 : 1;
        if (w16) exp16_q.push_back({exp_flg, exp_res[15:0]});
        else     exp_q.push_back({exp_flg, exp_res[7:0]});
        send_byte(w16, 8'hA5);
        send_byte(w16, opc);
        if (!opc[3]) begin
            for (int i = nb - 1; i >= 0; i--) send_byte(w16, a[i*8 +: 8]);
        end
        for (int i = nb - 1; i >= 0; i--) send_byte(w16, b[i*8 +: 8]);
    endtask

    // Called right after the last byte: done must appear one edge later.
    task automatic wait_done(input string name, input bit w16);
        int  lat;
        logic d, bz;
        lat = 0;
        while (lat < 8) begin
            @(negedge clk);
            d  = w16 ? done16 : done;
            bz = w16 ? busy16 : busy;
            if (d) begin
                check({name, " busy at done"}, 32'(bz), 32'd0);
                break;
            end
            if (lat == 0) check({name, " busy in exec"}, 32'(bz), 32'd1);
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'd1);
    endtask

    task automatic count_pwm(input string name, input int exp_hi);
        int hi;
        hi = 0;
        repeat (600) @(posedge clk);
        repeat (256) begin
            @(negedge clk);
            if (pwm_out) hi++;
        end
        check(name, 32'(hi), 32'(exp_hi));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, e0, w;

        vecs[0]  = '{8'h00, 8'h7F, 8'h01, 8'h80, 4'b1010};
        vecs[1]  = '{8'h01, 8'h00, 8'h01, 8'hFF, 4'b0110};
        vecs[2]  = '{8'h05, 8'h81, 8'h01, 8'h02, 4'b0100};
        vecs[3]  = '{8'h07, 8'h81, 8'h01, 8'hC0, 4'b0110};
        vecs[4]  = '{8'h00, 8'hFF, 8'h01, 8'h00, 4'b0101};
        vecs[5]  = '{8'h01, 8'h80, 8'h01, 8'h7F, 4'b1000};
        vecs[6]  = '{8'h02, 8'hF0, 8'h3C, 8'h30, 4'b0000};
        vecs[7]  = '{8'h03, 8'hF0, 8'h0F, 8'hFF, 4'b0010};
        vecs[8]  = '{8'h04, 8'hAA, 8'hAA, 8'h00, 4'b0001};
        vecs[9]  = '{8'h06, 8'h85, 8'h03, 8'h10, 4'b0100};
        vecs[10] = '{8'h05, 8'hC3, 8'h00, 8'hC3, 4'b0010};
        vecs[11] = '{8'h05, 8'h03, 8'h0F, 8'h80, 4'b0110};
        vecs[12] = '{8'h07, 8'h80, 8'h07, 8'hFF, 4'b0010};
        vecs[13] = '{8'h01, 8'h05, 8'h05, 8'h00, 4'b0001};
        vecs[14] = '{8'h13, 8'h0F, 8'h30, 8'h3F, 4'b0000};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset result", 32'(result), 32'd0);
        check("reset flags", 32'(flags), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset err", 32'(err_timeout), 32'd0);
        check("reset pwm", 32'(pwm_out), 32'd0);
        check("reset result16", 32'(result16), 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++) begin
            d0 = done_cnt;
            send_frame(1'b0, vecs[i].opc, 32'(vecs[i].a), 32'(vecs[i].b), 32'(vecs[i].res), vecs[i].flg);
            wait_done($sformatf("vec%0d", i), 1'b0);
            @(negedge clk);
            check($sformatf("vec%0d done pulses", i), 32'(done_cnt - d0), 32'd1);
            check($sformatf("vec%0d done width", i), 32'(done), 32'd0);
            @(posedge clk);
            #1;
        end

        // Chain: A5 08 01 after 0x80 -> 0x81, three bytes only.
        send_frame(1'b0, 8'h00, 32'h7F, 32'h01, 32'h80, 4'b1010);
        wait_done("preload", 1'b0);
        @(posedge clk);
        #1;
        exp_q.push_back({4'b0010, 8'h81});
        send_byte(1'b0, 8'hA5);
        send_byte(1'b0, 8'h08);
        @(negedge clk);
        check("chain busy", 32'(busy), 32'd1);
        check("chain no early done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        send_byte(1'b0, 8'h01);
        wait_done("chain", 1'b0);
        @(posedge clk);
        #1;

        // A header arriving during EXEC must be dropped.
        exp_q.push_back({4'b0000, 8'h02});
        send_byte(1'b0, 8'hA5);
        send_byte(1'b0, 8'h00);
        send_byte(1'b0, 8'h01);
        send_byte(1'b0, 8'h01);
        send_byte(1'b0, 8'hA5);
        @(negedge clk);
        check("exec drop done", 32'(done), 32'd1);
        check("exec drop busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check("exec drop busy later", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        // Timeout after A5 00 7F: result 0x02 must survive.
        e0 = err_cnt;
        send_byte(1'b0, 8'hA5);
        send_byte(1'b0, 8'h00);
        send_byte(1'b0, 8'h7F);
        w = 0;
        while (w < TO + 10) begin
            @(negedge clk);
            if (err_timeout) break;
            w++;
        end
        check("timeout cycles", 32'(w), 32'(TO));
        check("timeout busy", 32'(busy), 32'd0);
        check("timeout result", 32'(result), 32'h02);
        check("timeout flags", 32'(flags), 32'd0);
        @(negedge clk);
        check("timeout pulse width", 32'(err_timeout), 32'd0);
        check("timeout pulses", 32'(err_cnt - e0), 32'd1);
        @(posedge clk);
        #1;

        // Junk in IDLE is ignored.
        d0 = done_cnt;
        send_byte(1'b0, 8'h12);
        send_byte(1'b0, 8'h34);
        @(negedge clk);
        check("junk busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check("junk done", 32'(done_cnt - d0), 32'd0);
        @(posedge clk);
        #1;

        // Byte arriving exactly at timeout expiry is accepted.
        e0 = err_cnt;
        exp_q.push_back({4'b1010, 8'h80});
        send_byte(1'b0, 8'hA5);
        send_byte(1'b0, 8'h00);
        send_byte(1'b0, 8'h7F);
        repeat (TO - 1) @(posedge clk);
        #1;
        send_byte(1'b0, 8'h01);
        wait_done("race", 1'b0);
        check("race no timeout", 32'(err_cnt - e0), 32'd0);
        @(posedge clk);
        #1;

        count_pwm("pwm half", 128);

        // Reset in mid-frame and mid-period.
        send_byte(1'b0, 8'hA5);
        send_byte(1'b0, 8'h00);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst result", 32'(result), 32'd0);
        check("rst flags", 32'(flags), 32'd0);
        check("rst pwm", 32'(pwm_out), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        count_pwm("pwm zero", 0);
        send_frame(1'b0, 8'h00, 32'h01, 32'h02, 32'h03, 4'b0000);
        wait_done("post reset", 1'b0);
        count_pwm("pwm three", 3);
        send_frame(1'b0, 8'h01, 32'h00, 32'h01, 32'hFF, 4'b0110);
        wait_done("full scale", 1'b0);
        count_pwm("pwm full", 255);

        // 16-bit instance.
        send_frame(1'b1, 8'h00, 32'h1234, 32'h0001, 32'h1235, 4'b0000);
        wait_done("w16 add", 1'b1);
        send_frame(1'b1, 8'h01, 32'h0000, 32'h0001, 32'hFFFF, 4'b0110);
        wait_done("w16 sub", 1'b1);
        send_frame(1'b1, 8'h05, 32'h8001, 32'h0011, 32'h0002, 4'b0100);
        wait_done("w16 shl", 1'b1);
        send_frame(1'b1, 8'h08, 32'h0000, 32'h0003, 32'h0005, 4'b0000);
        wait_done("w16 chain", 1'b1);
        send_frame(1'b1, 8'h00, 32'h7FFF, 32'h0001, 32'h8000, 4'b1010);
        wait_done("w16 ovf", 1'b1);

        repeat (4) @(negedge clk);
        check("pending8", 32'(exp_q.size()), 32'd0);
        check("pending16", 32'(exp16_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
